tone_pwm_synth: RTL and testbench

Single-voice tone generator for the audio controller. It turns a 6-bit note code and a 4-bit volume into a 1-bit PWM audio stream. Inside, a note-period lookup sets the rate at which a 64-step sine table is walked, and a volume-scaled 8-bit PWM stage converts each sine sample to a duty cycle. It sits between the note sequencer and the board audio pin, running on the 100 MHz system clock.

---
 rtl/tone_pwm_synth.sv | 198 +++++++++++++++++++
 tb/tb_tone_pwm_synth.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_pwm_synth.sv
// Single-voice tone generator: note-period lookup paces a 64-step sine walk, and a
// volume-scaled 8-bit PWM stage turns each sample into a 1-bit audio stream.
module tone_pwm_synth #(
    parameter int unsigned COUNTER_MAX = 11945
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] TONE,
    input  logic [3:0] VOL,
    output logic       P
);

    localparam logic [13:0] CntMax = 14'(COUNTER_MAX);

    logic [13:0] period;
    logic [7:0]  duty;
    logic [11:0] prod;
    logic [7:0]  eff;
    logic        active;

    logic [13:0] step_cnt;
    logic [5:0]  idx;
    logic [7:0]  pwm_cnt;

    assign active = (VOL != 4'd0) && (TONE != 6'd0);

    // Clocks per sine step minus one: round(100e6 / (64 * f_note)), C3 upward.
    always_comb begin
        period = 14'd0;
        case (TONE)
            6'd0:  period = 14'd0;
            6'd1:  period = 14'd11945;
            6'd2:  period = 14'd11274;
            6'd3:  period = 14'd10641;
            6'd4:  period = 14'd10044;
            6'd5:  period = 14'd9480;
            6'd6:  period = 14'd8948;
            6'd7:  period = 14'd8446;
            6'd8:  period = 14'd7972;
            6'd9:  period = 14'd7525;
            6'd10: period = 14'd7102;
            6'd11: period = 14'd6704;
            6'd12: period = 14'd6327;
            6'd13: period = 14'd5972;
            6'd14: period = 14'd5637;
            6'd15: period = 14'd5321;
            6'd16: period = 14'd5022;
            6'd17: period = 14'd4740;
            6'd18: period = 14'd4474;
            6'd19: period = 14'd4223;
            6'd20: period = 14'd3986;
            6'd21: period = 14'd3762;
            6'd22: period = 14'd3551;
            6'd23: period = 14'd3352;
            6'd24: period = 14'd3164;
            6'd25: period = 14'd2986;
            6'd26: period = 14'd2819;
            6'd27: period = 14'd2660;
            6'd28: period = 14'd2511;
            6'd29: period = 14'd2370;
            6'd30: period = 14'd2237;
            6'd31: period = 14'd2112;
            6'd32: period = 14'd1993;
            6'd33: period = 14'd1881;
            6'd34: period = 14'd1776;
            6'd35: period = 14'd1676;
            6'd36: period = 14'd1582;
            6'd37: period = 14'd1493;
            6'd38: period = 14'd1409;
            6'd39: period = 14'd1330;
            6'd40: period = 14'd1256;
            6'd41: period = 14'd1185;
            6'd42: period = 14'd1119;
            6'd43: period = 14'd1056;
            6'd44: period = 14'd997;
            6'd45: period = 14'd941;
            6'd46: period = 14'd888;
            6'd47: period = 14'd838;
            6'd48: period = 14'd791;
            6'd49: period = 14'd747;
            6'd50: period = 14'd705;
            6'd51: period = 14'd665;
            6'd52: period = 14'd628;
            6'd53: period = 14'd593;
            6'd54: period = 14'd559;
            6'd55: period = 14'd528;
            6'd56: period = 14'd498;
            6'd57: period = 14'd470;
            6'd58: period = 14'd444;
            6'd59: period = 14'd419;
            6'd60: period = 14'd395;
            6'd61: period = 14'd373;
            6'd62: period = 14'd352;
            6'd63: period = 14'd333;
            default: period = 14'd0;
        endcase
    end

    // One sine cycle, offset-binary around 128 so the duty never reaches 0.
    always_comb begin
        duty = 8'd128;
        case (idx)
            6'd0:  duty = 8'd128;
            6'd1:  duty = 8'd140;
            6'd2:  duty = 8'd153;
            6'd3:  duty = 8'd165;
            6'd4:  duty = 8'd177;
            6'd5:  duty = 8'd188;
            6'd6:  duty = 8'd199;
            6'd7:  duty = 8'd209;
            6'd8:  duty = 8'd218;
            6'd9:  duty = 8'd226;
            6'd10: duty = 8'd234;
            6'd11: duty = 8'd240;
            6'd12: duty = 8'd245;
            6'd13: duty = 8'd250;
            6'd14: duty = 8'd253;
            6'd15: duty = 8'd254;
            6'd16: duty = 8'd255;
            6'd17: duty = 8'd254;
            6'd18: duty = 8'd253;
            6'd19: duty = 8'd250;
            6'd20: duty = 8'd245;
            6'd21: duty = 8'd240;
            6'd22: duty = 8'd234;
            6'd23: duty = 8'd226;
            6'd24: duty = 8'd218;
            6'd25: duty = 8'd209;
            6'd26: duty = 8'd199;
            6'd27: duty = 8'd188;
            6'd28: duty = 8'd177;
            6'd29: duty = 8'd165;
            6'd30: duty = 8'd153;
            6'd31: duty = 8'd140;
            6'd32: duty = 8'd128;
            6'd33: duty = 8'd116;
            6'd34: duty = 8'd103;
            6'd35: duty = 8'd91;
            6'd36: duty = 8'd79;
            6'd37: duty = 8'd68;
            6'd38: duty = 8'd57;
            6'd39: duty = 8'd47;
            6'd40: duty = 8'd38;
            6'd41: duty = 8'd30;
            6'd42: duty = 8'd22;
            6'd43: duty = 8'd16;
            6'd44: duty = 8'd11;
            6'd45: duty = 8'd6;
            6'd46: duty = 8'd3;
            6'd47: duty = 8'd2;
            6'd48: duty = 8'd1;
            6'd49: duty = 8'd2;
            6'd50: duty = 8'd3;
            6'd51: duty = 8'd6;
            6'd52: duty = 8'd11;
            6'd53: duty = 8'd16;
            6'd54: duty = 8'd22;
            6'd55: duty = 8'd30;
            6'd56: duty = 8'd38;
            6'd57: duty = 8'd47;
            6'd58: duty = 8'd57;
            6'd59: duty = 8'd68;
            6'd60: duty = 8'd79;
            6'd61: duty = 8'd91;
            6'd62: duty = 8'd103;
            6'd63: duty = 8'd116;
            default: duty = 8'd128;
        endcase
    end

    // Full 12-bit product before dropping the low nibble keeps VOL=15 just under full scale.
    assign prod = {4'd0, duty} * {8'd0, VOL};
    assign eff  = 8'(prod >> 4);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            step_cnt <= 14'd0;
            idx      <= 6'd0;
            pwm_cnt  <= 8'd0;
            P        <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            P       <= active && (pwm_cnt < eff);
            if (active) begin
                if (step_cnt >= period) begin
                    step_cnt <= 14'd0;
                    idx      <= idx + 6'd1;
                end else if (step_cnt > CntMax) begin
                    // Out-of-range count left over from a slower note: restart without stepping.
                    step_cnt <= 14'd0;
                end else begin
                    step_cnt <= step_cnt + 14'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tone_pwm_synth.sv
// Directed bench for tone_pwm_synth: table-driven step-rate, volume and note-table vectors
// plus hand-written sequences for reset, rest/mute, note switching and sine sweep.
`timescale 1ns/1ps
module tb_tone_pwm_synth;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] tone;
    logic [3:0] vol;
    logic       p;
    logic [5:0] tone1;
    logic [3:0] vol1;
    logic       p1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tone_pwm_synth dut (
        .CLK  (clk),
        .RST  (rst),
        .TONE (tone),
        .VOL  (vol),
        .P    (p)
    );

    // Small ceiling so the out-of-range recovery path is reachable with the slowest note.
    tone_pwm_synth #(
        .COUNTER_MAX (100)
    ) dut1 (
        .CLK  (clk),
        .RST  (rst),
        .TONE (tone1),
        .VOL  (vol1),
        .P    (p1)
    );

    typedef struct {
        logic [5:0] tone;
        int         interval;
    } step_vec_t;

    typedef struct {
        logic [3:0] vol;
        int         highs;
    } vol_vec_t;

    typedef struct {
        logic [5:0] tone;
        int         period;
    } note_vec_t;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edges until idx changes; -1 if the budget runs out.
    task automatic wait_idx_change(input int budget, output int edges);
        logic [5:0] prev;
        prev  = dut.idx;
        edges = 0;
        while (edges < budget) begin
            @(negedge clk);
            edges++;
            if (dut.idx != prev) return;
        end
        edges = -1;
    endtask

    task automatic count_high(input int n, output int highs, output int first_low);
        highs     = 0;
        first_low = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (p) highs++;
            else if (first_low < 0) first_low = i;
        end
    endtask

    function automatic int exp_period(input int n);
        real r;
        if (n == 0) return 0;
        r = 1.0e8 / (64.0 * 130.8128 * $pow(2.0, (n - 1) / 12.0));
        return $rtoi($floor(r + 0.5));
    endfunction

    function automatic int exp_duty(input int i);
        real r;
        r = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * i / 64.0);
        return $rtoi($floor(r + 0.5));
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        step_vec_t sv[3];
        vol_vec_t  vv[4];
        note_vec_t nv[5];
        int edges, highs, first_low, held_step, held_idx, prev_idx, total, n_seen, max_cnt, wraps;
        int last_cnt;
        bit seen[64];

        sv[0] = '{6'd63, 334};
        sv[1] = '{6'd10, 7103};
        sv[2] = '{6'd1, 11946};
        vv[0] = '{4'd15, 239};
        vv[1] = '{4'd0, 0};
        vv[2] = '{4'd8, 127};
        vv[3] = '{4'd1, 15};
        nv[0] = '{6'd0, 0};
        nv[1] = '{6'd1, 11945};
        nv[2] = '{6'd10, 7102};
        nv[3] = '{6'd13, 5972};
        nv[4] = '{6'd63, 333};

        rst = 1'b1; tone = 6'd13; vol = 4'd15; tone1 = 6'd1; vol1 = 4'd15;
        step(2);
        check("reset_p", int'(p), 0);
        check("reset_idx", int'(dut.idx), 0);
        check("reset_step_cnt", int'(dut.step_cnt), 0);
        check("reset_pwm_cnt", int'(dut.pwm_cnt), 0);

        // First frame after release: idx 0, duty 128, eff 120.
        rst = 1'b0;
        count_high(256, highs, first_low);
        check("frame_high_count", highs, 120);
        check("frame_first_low", first_low, 120);
        step(1);
        check("pre_rest_p", int'(p), 1);
        check("pre_rest_step_cnt", int'(dut.step_cnt), 257);

        // Rest, then mute: P low from the first edge, stepping frozen.
        tone = 6'd0;
        held_step = int'(dut.step_cnt);
        held_idx  = int'(dut.idx);
        count_high(1024, highs, first_low);
        check("rest_p_high", highs, 0);
        check("rest_step_hold", int'(dut.step_cnt), held_step);
        tone = 6'd13; vol = 4'd0;
        count_high(1024, highs, first_low);
        check("mute_p_high", highs, 0);
        check("mute_step_hold", int'(dut.step_cnt), held_step);
        check("mute_idx_hold", int'(dut.idx), held_idx);

        // Note table sweep while muted (combinational, no edges needed).
        for (int t = 0; t < 64; t++) begin
            tone = 6'(t);
            #1;
            check($sformatf("period_%0d", t), int'(dut.period), exp_period(t));
        end
        for (int k = 0; k < 5; k++) begin
            tone = nv[k].tone;
            #1;
            check($sformatf("period_req_%0d", nv[k].tone), int'(dut.period), nv[k].period);
        end
        tone = 6'd13;
        @(negedge clk);
        check("still_muted_step", int'(dut.step_cnt), held_step);

        vol = 4'd15;
        step(1);
        check("resume_step_cnt", int'(dut.step_cnt), held_step + 1);
        check("resume_idx", int'(dut.idx), held_idx);

        // Step rate: each new tone applied right after a step, so the next step is period+1 away.
        tone = 6'd63;
        wait_idx_change(12000, edges);
        check("step_sync", int'(edges > 0), 1);
        for (int k = 0; k < 3; k++) begin
            prev_idx = int'(dut.idx);
            tone = sv[k].tone;
            wait_idx_change(sv[k].interval + 20, edges);
            check($sformatf("step_interval_tone%0d", sv[k].tone), edges, sv[k].interval);
            check($sformatf("step_idx_inc_tone%0d", sv[k].tone), int'(dut.idx),
                  (prev_idx + 1) % 64);
        end

        // Down-to-up note switch from a deep count.
        step(11000);
        check("switch_step_cnt", int'(dut.step_cnt), 11000);
        prev_idx = int'(dut.idx);
        tone = 6'd63;
        step(1);
        check("switch_step_clear", int'(dut.step_cnt), 0);
        check("switch_idx_inc", int'(dut.idx), (prev_idx + 1) % 64);

        // Full sine cycle at the highest note, checking every duty entry on the way.
        total  = 0;
        n_seen = 0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int k = 0; k < 64; k++) begin
            wait_idx_change(400, edges);
            check("sweep_step_interval", edges, 334);
            total += edges;
            check($sformatf("duty_%0d", dut.idx), int'(dut.duty), exp_duty(int'(dut.idx)));
            seen[dut.idx] = 1'b1;
        end
        for (int i = 0; i < 64; i++) if (seen[i]) n_seen++;
        check("sweep_cycle_clocks", total, 64 * 334);
        check("sweep_entries_seen", n_seen, 64);

        // Park on idx 16 (duty 255) under the slowest note, then scale the volume.
        edges = 0;
        while (dut.idx != 6'd16 && edges < 64 * 334 + 400) begin
            @(negedge clk);
            edges++;
        end
        check("park_idx16", int'(dut.idx), 16);
        tone = 6'd1;
        for (int k = 0; k < 4; k++) begin
            vol = vv[k].vol;
            step(2);
            count_high(256, highs, first_low);
            check($sformatf("vol%0d_high_count", vv[k].vol), highs, vv[k].highs);
        end
        check("vol_idx_held", int'(dut.idx), 16);

        // Recovery path on the low-ceiling instance: counts to 101, clears, never steps.
        max_cnt  = 0;
        wraps    = 0;
        last_cnt = int'(dut1.step_cnt);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (int'(dut1.step_cnt) > max_cnt) max_cnt = int'(dut1.step_cnt);
            if (last_cnt == 101 && dut1.step_cnt == 14'd0) wraps++;
            last_cnt = int'(dut1.step_cnt);
        end
        check("recover_max_cnt", max_cnt, 101);
        check("recover_wraps", int'(wraps >= 2), 1);
        check("recover_idx", int'(dut1.idx), 0);

        // Asynchronous reset mid-frame while P is high.
        edges = 0;
        while (!p && edges < 300) begin
            @(negedge clk);
            edges++;
        end
        check("async_pre_p", int'(p), 1);
        rst = 1'b1;
        #1;
        check("async_p", int'(p), 0);
        check("async_idx", int'(dut.idx), 0);
        check("async_step_cnt", int'(dut.step_cnt), 0);
        check("async_pwm_cnt", int'(dut.pwm_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        // idx 0, duty 128, VOL 1: eff 8.
        count_high(256, highs, first_low);
        check("post_reset_vol1_high", highs, 8);
        check("post_reset_first_low", first_low, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
